// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Preset countdown timer on an HH:MM:SS.cc BCD digit chain. A preset is loaded
// while stopped, then decremented by one centisecond per prescaler tick with
// borrow across the digits. At 00:00:00.00 the timer stops, flags expiry and
// blinks an alarm until acknowledged. The displayed value can be frozen while
// counting continues underneath.
//
// Parameters:
//   TICK_CYCLES  clk cycles per centisecond tick
//   BLINK_TICKS  ticks per alarm toggle while expired
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   load         pulse: latch preset into the count (only while stopped)
//   start_pause  pulse: toggle run/pause, or acknowledge the alarm
//   freeze       pulse: toggle display hold
//   preset[31:0] BCD {hh_hi,hh_lo,mm_hi,mm_lo,ss_hi,ss_lo,cs_hi,cs_lo}
//   disp[31:0]   displayed BCD value, same nibble order as preset
//   running      count is decrementing
//   expired      sticky: count reached zero
//   done         one-cycle pulse when the count reaches zero
//   alarm        blinking indicator while expired
//   load_err     one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int TICK_CYCLES = 500000,
  parameter int BLINK_TICKS = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        start_pause,
  input  logic        freeze,
  input  logic [31:0] preset,
  output logic [31:0] disp,
  output logic        running,
  output logic        expired,
  output logic        done,
  output logic        alarm,
  output logic        load_err
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PS_LAST    = PW'(TICK_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  // Nibble index of each digit, nibble 0 = cs_lo.
  localparam int SS_HI = 3;
  localparam int MM_HI = 5;

  logic [31:0]   count_q, count_d;
  logic [31:0]   disp_q, disp_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          done_q, done_d;
  logic          alarm_q, alarm_d;
  logic          load_err_q, load_err_d;
  logic          hold_q, hold_d;

  logic          tick;
  logic [31:0]   count_dec;

  // Digit ranges: lo digits and both hi digits of hh/cs are 0-9, the tens of
  // minutes and seconds are 0-5.
  function automatic logic preset_valid(input logic [31:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == SS_HI || i == MM_HI) begin
        if (v[i*4 +: 4] > 4'd5) ok = 1'b0;
      end else begin
        if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Subtract one centisecond. A zero digit rolls to its maximum and passes the
  // borrow on; the first non-zero digit absorbs it. hh_hi never needs to roll
  // because a zero count is never decremented.
  function automatic logic [31:0] bcd_dec(input logic [31:0] v);
    logic [31:0] r;
    logic        borrow;
    logic [3:0]  dmax;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dmax = (i == SS_HI || i == MM_HI) ? 4'd5 : 4'd9;
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = dmax;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // The prescaler runs while counting and while expired (to pace the blink).
  assign tick      = (running_q || expired_q) && (prescaler_q == PS_LAST);
  assign count_dec = bcd_dec(count_q);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    count_d     = count_q;
    prescaler_d = prescaler_q;
    blink_d     = blink_q;
    running_d   = running_q;
    expired_d   = expired_q;
    done_d      = 1'b0;
    alarm_d     = alarm_q;
    load_err_d  = 1'b0;
    hold_d      = freeze ? ~hold_q : hold_q;
    // disp follows the count with one cycle of latency unless held.
    disp_d      = hold_q ? disp_q : count_q;

    if (running_q || expired_q) begin
      prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    end

    if (expired_q && tick) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        alarm_d = ~alarm_q;
      end else begin
        blink_d = blink_q + BW'(1);
      end
    end

    if (running_q && tick) begin
      count_d = count_dec;
    end

    // Expiry outranks load and start_pause arriving in the same cycle.
    if (running_q && tick && (count_dec == 32'd0)) begin
      running_d = 1'b0;
      expired_d = 1'b1;
      done_d    = 1'b1;
      alarm_d   = 1'b1;
      blink_d   = '0;
    end else if (load && !running_q) begin
      // An accepted (or rejected) load swallows a simultaneous start_pause.
      if (preset_valid(preset)) begin
        count_d     = preset;
        prescaler_d = '0;
        expired_d   = 1'b0;
        alarm_d     = 1'b0;
      end else begin
        load_err_d  = 1'b1;
      end
    end else if (start_pause) begin
      if (expired_q) begin
        expired_d = 1'b0;
        alarm_d   = 1'b0;
      end else if (count_q != 32'd0) begin
        running_d = ~running_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      count_q     <= '0;
      disp_q      <= '0;
      prescaler_q <= '0;
      blink_q     <= '0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
      load_err_q  <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      disp_q      <= disp_d;
      prescaler_q <= prescaler_d;
      blink_q     <= blink_d;
      running_q   <= running_d;
      expired_q   <= expired_d;
      done_q      <= done_d;
      alarm_q     <= alarm_d;
      load_err_q  <= load_err_d;
      hold_q      <= hold_d;
    end
  end

  assign disp     = disp_q;
  assign running  = running_q;
  assign expired  = expired_q;
  assign done     = done_q;
  assign alarm    = alarm_q;
  assign load_err = load_err_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Preset countdown timer that runs the stopwatch's digit chain in the opposite direction. It loads an HH:MM:SS.cc BCD preset and decrements it by one centisecond per tick, with borrow across the digits. It stops at 00:00:00.00 and raises an alarm. It drives a BCD display bus with a freeze/hold function; the board top level feeds that bus to the existing sevenseg decoders, and the start/freeze/load inputs come from the existing key debouncers.

Parameters:
TICK_CYCLES, 500000, clk cycles per centisecond tick (10 ms at 50 MHz)
BLINK_TICKS, 50, ticks per alarm toggle while expired (0.5 s)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  one-cycle pulse: latch preset into the count
start_pause  input  1  one-cycle pulse: toggle run/pause; acknowledges the alarm when expired
freeze  input  1  one-cycle pulse: toggle display hold
preset  input  32  BCD {hh_hi,hh_lo,mm_hi,mm_lo,ss_hi,ss_lo,cs_hi,cs_lo}, nibble [31:28] = hh_hi
disp  output  32  displayed BCD value, same nibble order as preset
running  output  1  count is decrementing
expired  output  1  sticky: count reached zero
done  output  1  one-cycle pulse on the cycle the count reaches zero
alarm  output  1  blinking indicator while expired, 0 otherwise
load_err  output  1  one-cycle pulse when a load is rejected for an invalid preset

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset (dominates everything): count = 0, disp = 0, prescaler = 0, blink counter = 0, running = expired = done = alarm = load_err = hold = 0.
- Valid preset:
  - every lo nibble is 0-9;
  - ss_hi and mm_hi are 0-5;
  - hh_hi is 0-9.
- Load, accepted only when running = 0:
  - valid preset: count <= preset, prescaler <= 0, expired <= 0, alarm <= 0;
  - invalid preset: count unchanged, load_err = 1 for one cycle.
  - Load while running is ignored with no error.
- start_pause:
  - if expired = 1: clear expired and alarm; running stays 0.
  - else if count == 0: ignored.
  - else: running <= ~running.
- Priority within one cycle: reset > expiry > load > start_pause. A load and a start_pause in the same cycle perform only the load.
- Prescaler:
  - counts 0..TICK_CYCLES-1 while running or expired; holds its value while paused.
  - At TICK_CYCLES-1 it wraps to 0 and issues a tick.
  - Pause then resume continues from the held value, with no restart.
- Decrement on a tick while running, subtracting 1 centisecond with borrow:
  - cs_lo 0→9 borrows, cs_hi 0→9, ss_lo 0→9, ss_hi 0→5, mm_lo 0→9, mm_hi 0→5, hh_lo 0→9, hh_hi decrements.
  - The count never underflows, because running = 0 whenever count == 0.
- Expiry: on a tick whose decrement yields all zeros, in the same cycle:
  - running <= 0, expired <= 1, done = 1 (one cycle), alarm <= 1, blink counter <= 0.
  - A start_pause arriving on that same cycle is ignored.
- Alarm: while expired, every tick increments the blink counter; at BLINK_TICKS-1 the counter wraps and alarm toggles.
- Display:
  - hold toggles on each freeze pulse.
  - hold = 0: disp <= count every cycle (one cycle of latency).
  - hold = 1: disp is frozen and counting continues underneath.
  - A load while hold = 1 does not update disp until hold is released.
- Wrap-around: none. The maximum preset 99:59:59.99 counts down normally.

Test Plan (bench uses TICK_CYCLES=4, BLINK_TICKS=2):
- Reset then idle: all outputs 0; start_pause with count 0 -> running stays 0.
- Load preset 00:00:01.00, start_pause -> after 4 ticks (16 cycles) disp = 00:00:00.96; after 100 ticks, done pulses once, running = 0, expired = 1, disp = 00:00:00.00.
- Borrow chain: load 01:00:00.00, run 1 tick -> disp = 00:59:59.99.
- Pause/hold: pause mid-count, wait 20 cycles -> disp unchanged. Resume -> the next tick arrives after the remaining prescaler cycles. freeze while running -> disp constant while the internal count keeps moving; second freeze -> disp catches up 1 cycle later.
- Invalid load: preset ss_hi = 6 -> load_err pulses, count unchanged. Load while running -> ignored, no load_err. Load and start_pause in the same cycle -> count loaded, running = 0.
- Expired alarm: after expiry, alarm toggles every 2 ticks (8 cycles). start_pause -> expired = alarm = 0. Reset asserted mid-count -> all outputs 0 on the next cycle.
